// File: rtl/instr_word_encoder_if.sv
// Request/response bundle for instr_word_encoder: control class + operand fields in,
// assembled instruction words out. Carries out_par only when ENC_PARITY_EN is defined.
interface instr_word_encoder_if #(
    parameter int unsigned CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [2:0]       wrw;
    logic [1:0]       aluop;
    logic [4:0]       rs;
    logic [4:0]       rt;
    logic [4:0]       rd;
    logic [4:0]       shamt;
    logic [5:0]       funct;
    logic [15:0]      imm;
    logic [25:0]      target;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_instr;
    logic             err;
    logic [CNT_W-1:0] out_count;
`ifdef ENC_PARITY_EN
    logic             out_par;
`endif

    modport master (
        output in_valid, op, wrw, aluop, rs, rt, rd, shamt, funct, imm, target, out_ready,
        input  in_ready, out_valid, out_instr, err, out_count
`ifdef ENC_PARITY_EN
        , input out_par
`endif
    );

    modport slave (
        input  in_valid, op, wrw, aluop, rs, rt, rd, shamt, funct, imm, target, out_ready,
        output in_ready, out_valid, out_instr, err, out_count
`ifdef ENC_PARITY_EN
        , output out_par
`endif
    );
endinterface

// File: rtl/instr_word_encoder.sv
// Assembles MIPS instruction words from {op,wrw,aluop} control classes and buffers them in a
// DEPTH-entry FIFO. Optional feature macro: ENC_PARITY_EN (per-entry parity bit, out_par).
module instr_word_encoder #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input logic               clk,
    input logic               rst_n,
    instr_word_encoder_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
`ifdef ENC_PARITY_EN
    localparam int unsigned W = 33;
`else
    localparam int unsigned W = 32;
`endif

    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [W-1:0] mem [DEPTH];
    logic         full;
    logic         empty;
    logic         legal;
    logic [31:0]  word;
    logic [W-1:0] entry;
    logic [W-1:0] head;
    logic         accept;
    logic         push;
    logic         pop;

    always_comb begin
        legal = 1'b1;
        word  = 32'd0;
        case ({bus.op, bus.wrw, bus.aluop})
            8'b001_100_10: word = {6'd0, bus.rs, bus.rt, bus.rd, bus.shamt, bus.funct};
            8'b010_110_00: word = {6'd35, bus.rs, bus.rt, bus.imm};
            8'b010_101_00: word = {6'd43, bus.rs, bus.rt, bus.imm};
            8'b010_000_01: word = {6'd4, bus.rs, bus.rt, bus.imm};
            8'b100_000_00: word = {6'd2, bus.target};
            default:       legal = 1'b0;
        endcase
    end

`ifdef ENC_PARITY_EN
    assign entry       = {^word, word};
    assign bus.out_par = head[32];
`else
    assign entry = word;
`endif

    // Same index bits with differing wrap bits means the write side has lapped the read side.
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);

    assign head          = mem[rd_ptr[AW-1:0]];
    assign bus.in_ready  = !full;
    assign bus.out_valid = !empty;
    assign bus.out_instr = head[31:0];

    assign accept = bus.in_valid && !full;
    assign push   = accept && legal;
    assign pop    = !empty && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            bus.err       <= 1'b0;
            bus.out_count <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            bus.err <= accept && !legal;
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= entry;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr        <= rd_ptr + 1'b1;
                bus.out_count <= bus.out_count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_instr_word_encoder.sv
// Directed bench for instr_word_encoder: encode table, backpressure, illegal drop, reset.
module tb_instr_word_encoder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;
    logic [31:0] exp_w [5];

    instr_word_encoder_if #(.CNT_W(16)) bus ();

    instr_word_encoder #(.DEPTH(4), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        assert (obs === expv)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic set_fields(input logic [2:0] op, input logic [2:0] wrw,
                              input logic [1:0] aluop, input logic [4:0] rs,
                              input logic [4:0] rt, input logic [4:0] rd,
                              input logic [4:0] shamt, input logic [5:0] funct,
                              input logic [15:0] imm, input logic [25:0] target);
        bus.op = op; bus.wrw = wrw; bus.aluop = aluop; bus.rs = rs; bus.rt = rt;
        bus.rd = rd; bus.shamt = shamt; bus.funct = funct; bus.imm = imm;
        bus.target = target;
    endtask

    // 0: R add, 1: lw, 2: sw, 3: beq, 4: j
    task automatic set_vec(input int idx);
        case (idx)
            0: set_fields(3'b001, 3'b100, 2'b10, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0);
            1: set_fields(3'b010, 3'b110, 2'b00, 5'd29, 5'd8, 5'd0, 5'd0, 6'h0, 16'h4, 26'h0);
            2: set_fields(3'b010, 3'b101, 2'b00, 5'd29, 5'd8, 5'd0, 5'd0, 6'h0, 16'h4, 26'h0);
            3: set_fields(3'b010, 3'b000, 2'b01, 5'd1, 5'd2, 5'd0, 5'd0, 6'h0, 16'hFFFF, 26'h0);
            default: set_fields(3'b100, 3'b000, 2'b00, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0,
                                26'h0100000);
        endcase
    endtask

    // Called at a negedge; returns at the next negedge with in_valid dropped.
    task automatic push_vec(input int idx);
        set_vec(idx);
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic acc;
        exp_w[0] = 32'h0022_1820;
        exp_w[1] = 32'h8FA8_0004;
        exp_w[2] = 32'hAFA8_0004;
        exp_w[3] = 32'h1022_FFFF;
        exp_w[4] = 32'h0810_0000;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        set_vec(0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_count", 64'(bus.out_count), 64'd0);
        check("rst_err", 64'(bus.err), 64'd0);
        check("rst_out_instr", 64'(bus.out_instr), 64'd0);

        // Test 1: R-type, latency 1, count on pop
        push_vec(0);
        check("t1_out_valid", 64'(bus.out_valid), 64'd1);
        check("t1_out_instr", 64'(bus.out_instr), 64'h0022_1820);
        check("t1_count_before", 64'(bus.out_count), 64'd0);
`ifdef ENC_PARITY_EN
        check("t6_par_r", 64'(bus.out_par), 64'd1);
`endif
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("t1_count_after", 64'(bus.out_count), 64'd1);
        check("t1_empty", 64'(bus.out_valid), 64'd0);

        // Test 2: lw, sw, beq, j in order
        for (int i = 1; i < 5; i++) push_vec(i);
        bus.out_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            check($sformatf("t2_valid_%0d", i), 64'(bus.out_valid), 64'd1);
            check($sformatf("t2_instr_%0d", i), 64'(bus.out_instr), 64'(exp_w[i]));
`ifdef ENC_PARITY_EN
            if (i == 4) check("t6_par_j", 64'(bus.out_par), 64'd0);
`endif
            @(posedge clk);
            @(negedge clk);
        end
        bus.out_ready = 1'b0;
        check("t2_count", 64'(bus.out_count), 64'd5);
        check("t2_empty", 64'(bus.out_valid), 64'd0);

        // Test 3: fill to DEPTH under backpressure, fifth word held off
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push_vec(i);
            check($sformatf("t3_in_ready_%0d", i), 64'(bus.in_ready), (i == 3) ? 64'd0 : 64'd1);
        end
        set_vec(4);
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t3_held_ready", 64'(bus.in_ready), 64'd0);
        check("t3_held_count", 64'(bus.out_count), 64'd0);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("t3_valid_%0d", k), 64'(bus.out_valid), 64'd1);
            check($sformatf("t3_instr_%0d", k), 64'(bus.out_instr), 64'(exp_w[k]));
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk);
            @(negedge clk);
            if (acc) bus.in_valid = 1'b0;
        end
        bus.out_ready = 1'b0;
        check("t3_count", 64'(bus.out_count), 64'd5);
        check("t3_empty", 64'(bus.out_valid), 64'd0);

        // Test 4: illegal class is dropped with a single err pulse
        set_fields(3'b010, 3'b111, 2'b11, 5'd1, 5'd2, 5'd3, 5'd0, 6'h0, 16'h0, 26'h0);
        bus.in_valid = 1'b1;
        check("t4_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("t4_err_pulse", 64'(bus.err), 64'd1);
        check("t4_no_word", 64'(bus.out_valid), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("t4_err_clear", 64'(bus.err), 64'd0);
        check("t4_count", 64'(bus.out_count), 64'd5);
        push_vec(3);
        check("t4_next_valid", 64'(bus.out_valid), 64'd1);
        check("t4_next_instr", 64'(bus.out_instr), 64'(exp_w[3]));
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("t4_next_count", 64'(bus.out_count), 64'd6);

        // Test 5: async reset with words buffered
        for (int i = 0; i < 3; i++) push_vec(i);
        check("t5_buffered", 64'(bus.out_valid), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check("t5_rst_valid", 64'(bus.out_valid), 64'd0);
        check("t5_rst_count", 64'(bus.out_count), 64'd0);
        check("t5_rst_instr", 64'(bus.out_instr), 64'd0);
        check("t5_rst_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        push_vec(4);
        bus.out_ready = 1'b1;
        check("t5_valid", 64'(bus.out_valid), 64'd1);
        check("t5_instr", 64'(bus.out_instr), 64'(exp_w[4]));
        @(posedge clk);
        @(negedge clk);
        check("t5_drained", 64'(bus.out_valid), 64'd0);
        check("t5_count", 64'(bus.out_count), 64'd1);
        @(posedge clk);
        @(negedge clk);
        check("t5_count_hold", 64'(bus.out_count), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
